// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side bus responder: widths, length codes,
// controller states and byte-lane helpers.
package mem_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;

    localparam logic LEN_BYTE = 1'b0;
    localparam logic LEN_WORD = 1'b1;

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

    // Word accesses touch every lane; byte accesses touch only the addressed lane.
    function automatic logic [3:0] lane_mask(input logic len, input logic [1:0] lane);
        return (len == LEN_WORD) ? 4'hF : (4'b0001 << lane);
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/mem_byte_lane_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are never reset.
module mem_byte_lane_array
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              Clk,
    input  logic [3:0]        be_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        for (int l = 0; l < 4; l++) begin
            if (be_i[l]) begin
                mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Cycle-accurate memory model on the processor bus with programmable wait states.
// Define MEM_RESP_ERR_EN to add the Err output and error-checked accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Length,
    input  logic              Rd,
    input  logic              Wr,
    input  logic              Enable,
    output logic              Rdy,
`ifdef MEM_RESP_ERR_EN
    output logic              Err,
`endif
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              capture;

    logic [ADDR_W-1:0] addr_q;
    logic              len_q, rd_q, wr_q;
    logic [DATA_W-1:0] din_q;

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata, rdata, rd_val;
    logic              req_err;

    assign idx  = addr_q[2 +: IDX_W];
    assign lane = addr_q[1:0];

`ifdef MEM_RESP_ERR_EN
    logic err_q, err_d;

    assign req_err = (rd_q && wr_q)
                   || (len_q == LEN_WORD && lane != 2'b00)
                   || ((addr_q >> (IDX_W + 2)) != '0);
    assign Err     = err_q;
`else
    // Upper address bits wrap silently when error checking is compiled out.
    logic addr_hi_unused;

    assign addr_hi_unused = ^addr_q[ADDR_W-1:IDX_W+2];
    assign req_err        = 1'b0;
`endif

    // Rd has priority over Wr, so a write only happens for a pure write request.
    assign be    = (state_q == ACCESS && wr_q && !rd_q && !req_err) ? lane_mask(len_q, lane) : 4'b0000;
    assign wdata = (len_q == LEN_WORD) ? din_q : {4{din_q[7:0]}};

    always_comb begin
        rd_val = (len_q == LEN_WORD) ? rdata : {{(DATA_W-8){1'b0}}, lane_byte(rdata, lane)};
        if (req_err) begin
            rd_val = DATA_W'(ERR_PATTERN);
        end
    end

    mem_byte_lane_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .Clk     (Clk),
        .be_i    (be),
        .idx_i   (idx),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        dout_d  = dout_q;
        capture = 1'b0;
`ifdef MEM_RESP_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (Enable) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (!Enable) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q != '0) ? cnt_q - 4'd1 : '0;
                    if (cnt_q <= 4'd1) begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                rdy_d   = 1'b1;
                state_d = DONE;
                if (rd_q) begin
                    dout_d = rd_val;
                end
`ifdef MEM_RESP_ERR_EN
                err_d = req_err;
`endif
            end
            DONE: begin
                if (!Enable) begin
                    rdy_d   = 1'b0;
                    state_d = IDLE;
`ifdef MEM_RESP_ERR_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
`ifdef MEM_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
`ifdef MEM_RESP_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Request fields are frozen at capture; later bus activity is ignored until IDLE.
    always_ff @(posedge Clk) begin
        if (capture) begin
            addr_q <= Addr;
            len_q  <= Length;
            rd_q   <= Rd;
            wr_q   <= Wr;
            din_q  <= DataIn;
        end
    end

    assign Rdy     = rdy_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed bus transactions plus randomized traffic
// compared against a byte-addressed reference model.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int MEMB  = DEPTH * 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [23:0] Addr;
    logic        Length, Rd, Wr, Enable, en_z;
    logic [31:0] DataIn;
    logic        Rdy, Rdy_z;
    logic [31:0] DataOut, DataOut_z;
`ifdef MEM_RESP_ERR_EN
    logic        Err, Err_z;
`endif

    always #5 Clk = ~Clk;

    mem_responder #(
        .ADDR_W(24), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .Length(Length), .Rd(Rd), .Wr(Wr),
        .Enable(Enable), .Rdy(Rdy),
`ifdef MEM_RESP_ERR_EN
        .Err(Err),
`endif
        .DataIn(DataIn), .DataOut(DataOut)
    );

    mem_responder #(
        .ADDR_W(24), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
    ) dut_z (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .Length(Length), .Rd(Rd), .Wr(Wr),
        .Enable(en_z), .Rdy(Rdy_z),
`ifdef MEM_RESP_ERR_EN
        .Err(Err_z),
`endif
        .DataIn(DataIn), .DataOut(DataOut_z)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  mdl [2][MEMB];
    logic [31:0] exp_dout [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic rdy_of(input int z);
        return (z == 1) ? Rdy_z : Rdy;
    endfunction

    function automatic logic [31:0] dout_of(input int z);
        return (z == 1) ? DataOut_z : DataOut;
    endfunction

    function automatic logic [31:0] m_read(input int z, input logic [23:0] a, input logic len);
        int b;
        b = int'(a) % MEMB;
        if (len) begin
            b = b - (b % 4);
            return {mdl[z][b+3], mdl[z][b+2], mdl[z][b+1], mdl[z][b]};
        end
        return {24'h0, mdl[z][b]};
    endfunction

    function automatic void m_write(input int z, input logic [23:0] a, input logic len,
                                    input logic [31:0] d);
        int b;
        b = int'(a) % MEMB;
        if (len) begin
            b = b - (b % 4);
            for (int i = 0; i < 4; i++) mdl[z][b+i] = d[8*i +: 8];
        end else begin
            mdl[z][b] = d[7:0];
        end
    endfunction

    // One full handshake: present request, count edges to Rdy, check data,
    // optionally hold Enable, then release and confirm Rdy drops.
    task automatic do_req(input int z, input logic [23:0] a, input logic len, input logic rd,
                          input logic wr, input logic [31:0] d, input int hold);
        int k;
        @(negedge Clk);
        Addr = a; Length = len; Rd = rd; Wr = wr; DataIn = d;
        if (z == 1) en_z = 1'b1; else Enable = 1'b1;
        k = 0;
        do begin
            @(posedge Clk); #1;
            k++;
            if (k == 1) begin
                Addr = 24'($urandom); Length = 1'($urandom); Rd = 1'($urandom);
                Wr = 1'($urandom); DataIn = $urandom;
            end
        end while (rdy_of(z) == 1'b0 && k < 20);
        chk("latency", 32'(k), (z == 1) ? 32'd2 : 32'd4);
        if (rd) exp_dout[z] = m_read(z, a, len);
        else if (wr) m_write(z, a, len, d);
        chk("dataout", dout_of(z), exp_dout[z]);
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            chk("hold_rdy", 32'(rdy_of(z)), 32'd1);
            chk("hold_dataout", dout_of(z), exp_dout[z]);
        end
        @(negedge Clk);
        if (z == 1) en_z = 1'b0; else Enable = 1'b0;
        @(posedge Clk); #1;
        chk("rdy_release", 32'(rdy_of(z)), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; en_z = 1'b0;
        Addr = '0; Length = 1'b0; Rd = 1'b0; Wr = 1'b0; DataIn = '0;
        exp_dout[0] = '0; exp_dout[1] = '0;
        #2 Reset = 1'b0;
        #1;
        chk("reset_rdy", 32'(Rdy), 32'd0);
        chk("reset_dataout", DataOut, 32'd0);
        chk("reset_rdy_z", 32'(Rdy_z), 32'd0);
        chk("reset_dataout_z", DataOut_z, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // Word write/read and byte lanes
        do_req(0, 24'h000010, 1'b1, 1'b0, 1'b1, 32'h11223344, 0);
        do_req(0, 24'h000010, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        chk("word_read", DataOut, 32'h11223344);
        do_req(0, 24'h000012, 1'b0, 1'b0, 1'b1, 32'h000000AB, 0);
        chk("write_keeps_dataout", DataOut, 32'h11223344);
        do_req(0, 24'h000010, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        chk("byte_merge", DataOut, 32'h11AB3344);
        do_req(0, 24'h000013, 1'b0, 1'b1, 1'b0, 32'h0, 0);
        chk("byte_read", DataOut, 32'h00000011);

        // Abort during WAIT leaves storage untouched
        do_req(0, 24'h000020, 1'b1, 1'b0, 1'b1, 32'h5A5A1234, 0);
        @(negedge Clk);
        Addr = 24'h000020; Length = 1'b1; Rd = 1'b0; Wr = 1'b1; DataIn = 32'hFFFFFFFF; Enable = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        Enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            chk("abort_rdy", 32'(Rdy), 32'd0);
        end
        do_req(0, 24'h000020, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        chk("abort_no_write", DataOut, 32'h5A5A1234);

        // Hold in DONE, then back-to-back request
        do_req(0, 24'h000010, 1'b1, 1'b1, 1'b0, 32'h0, 5);
        do_req(0, 24'h000013, 1'b0, 1'b1, 1'b0, 32'h0, 0);

        // Forced alignment, address wrap, Rd&Wr priority, no-op
        do_req(0, 24'hABC016, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 0);
        do_req(0, 24'h000014, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        chk("align_wrap", DataOut, 32'hCAFEF00D);
        do_req(0, 24'h000014, 1'b1, 1'b1, 1'b1, 32'h01020304, 0);
        do_req(0, 24'h000014, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 0);
        chk("noop_dataout", DataOut, 32'hCAFEF00D);

        // Reset in WAIT of a write
        @(negedge Clk);
        Addr = 24'h000014; Length = 1'b1; Rd = 1'b0; Wr = 1'b1; DataIn = 32'h0; Enable = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        chk("rst_wait_rdy", 32'(Rdy), 32'd0);
        chk("rst_wait_dataout", DataOut, 32'd0);
        exp_dout[0] = '0; exp_dout[1] = '0;
        @(negedge Clk);
        Enable = 1'b0; Reset = 1'b1;
        do_req(0, 24'h000014, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        chk("rst_no_write", DataOut, 32'hCAFEF00D);

        // Reset while Rdy is high clears it without waiting for an edge
        @(negedge Clk);
        Addr = 24'h000010; Length = 1'b1; Rd = 1'b1; Wr = 1'b0; Enable = 1'b1;
        repeat (4) begin @(posedge Clk); #1; end
        chk("pre_rst_rdy", 32'(Rdy), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("rst_done_rdy", 32'(Rdy), 32'd0);
        chk("rst_done_dataout", DataOut, 32'd0);
        exp_dout[0] = '0; exp_dout[1] = '0;
        @(negedge Clk);
        Enable = 1'b0; Reset = 1'b1;

        // Zero wait states
        do_req(1, 24'h000040, 1'b1, 1'b0, 1'b1, 32'h0BADF00D, 0);
        do_req(1, 24'h000040, 1'b1, 1'b1, 1'b0, 32'h0, 3);
        chk("zw_word", DataOut_z, 32'h0BADF00D);
        do_req(1, 24'h000041, 1'b0, 1'b1, 1'b0, 32'h0, 0);
        chk("zw_byte", DataOut_z, 32'h000000F0);

        // Randomized traffic over a prefilled window, with aliased upper address bits
        for (int i = 0; i < 16; i++) begin
            do_req(0, 24'(i * 4), 1'b1, 1'b0, 1'b1, $urandom, 0);
        end
        for (int n = 0; n < 150; n++) begin
            logic [23:0] a;
            a = {12'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            do_req(0, a, 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's memory bus: address, length, read, write, enable, ready and the two 32-bit data buses.
- Accepts one request at a time and inserts a programmable number of wait states.
- Performs byte or word reads/writes on internal storage, then asserts ready until the processor drops enable.
- Sits opposite the processor in the computer top level and is a cycle-accurate, wait-state-capable memory model.

Parameters:
- ADDR_W, 24, request address width.
- DATA_W, 32, data bus width (fixed 4 byte lanes).
- DEPTH_WORDS, 1024, storage size in 32-bit words; must be a power of 2.
- WAIT_CYCLES, 2, wait states between request capture and ready (0..15).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Addr  in  ADDR_W  byte address from the processor.
- Length  in  1  0 = byte access, 1 = word access.
- Rd  in  1  read request.
- Wr  in  1  write request.
- Enable  in  1  request valid; held high by the processor until Rdy is seen.
- Rdy  out  1  access complete; DataOut is valid when Rdy is high on a read.
- DataIn  in  DATA_W  write data from the processor.
- DataOut  out  DATA_W  read data to the processor.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, Rdy=0, DataOut=0, wait counter=0.
  - Storage is NOT cleared.
- IDLE:
  - On a rising edge with Enable=1, latch Addr, Length, Rd, Wr and DataIn.
  - If WAIT_CYCLES>0, load the counter with WAIT_CYCLES and go to WAIT; otherwise go to ACCESS.
- WAIT:
  - Decrement the counter each cycle; go to ACCESS when the counter reaches 1.
  - Enable=0 in WAIT aborts: go to IDLE, no write, Rdy stays 0.
- ACCESS (one cycle):
  - Perform the access on the latched request; go to DONE.
  - Rdy is registered, so it rises on the edge leaving ACCESS.
  - Latency from the capturing edge to Rdy high is WAIT_CYCLES+2 edges.
- DONE:
  - Rdy=1 and DataOut is held.
  - Enable=0 → IDLE with Rdy=0 on the next edge.
  - A new request is accepted only after returning to IDLE (one-cycle turnaround).
- Addressing:
  - Word index = Addr[ADDR_W-1:2] modulo DEPTH_WORDS; upper bits wrap silently.
  - Lane = Addr[1:0].
- Word access:
  - Addr[1:0] is ignored (forced alignment).
  - Read returns the full word; write updates all 4 lanes.
- Byte access (little-endian lanes):
  - Read returns the lane byte zero-extended in DataOut[7:0].
  - Write updates only the selected lane from DataIn[7:0].
- Rd=1 and Wr=1 together: treat as a read (no write); Rdy is still returned.
- Rd=0 and Wr=0 with Enable=1: no-op; Rdy returned and DataOut unchanged.
- DataOut changes only on completion of a read. Writes leave DataOut at its previous value.
- Reset asserted mid-operation: abort immediately. A write not yet in ACCESS is never performed.
- Input changes after capture are ignored until IDLE.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- When defined:
  - Adds output port Err (1 bit), reset 0.
  - Err is asserted alongside Rdy in DONE when the request had Rd&Wr both set, a misaligned word (Length=1, Addr[1:0]≠0), or Addr beyond DEPTH_WORDS*4.
  - Erroneous writes are suppressed; erroneous reads return 32'hDEAD_BEEF.
- When undefined: no Err port, and behaviour is exactly as above (silent alignment/wrap, Rd priority).

Decomposition:
- Package mem_pkg:
  - ADDR_W and DATA_W defaults.
  - LEN_BYTE=1'b0 and LEN_WORD=1'b1.
  - State enum {IDLE, WAIT, ACCESS, DONE}.
  - Error read pattern constant.
- Sub-module mem_byte_lane_array:
  - DEPTH_WORDS×32 synchronous storage with a 4-bit byte write-enable and combinational read.
  - Keeps lane masking out of the FSM.
- The FSM, request latch and counter stay in mem_responder.

Test Plan:
- Word write then read:
  - Wr, Length=1, Addr=0x000010, DataIn=0x11223344, WAIT_CYCLES=2 → Rdy high 4 edges after capture.
  - Subsequent word read of 0x000010 → DataOut=0x11223344.
- Byte lane write:
  - Byte write 0xAB at Addr=0x000012 over word 0x11223344 → word read returns 0x11AB3344.
  - Byte read at 0x000013 → DataOut=0x00000011.
- Abort in WAIT:
  - Start word write 0xFFFFFFFF to 0x20, drop Enable during WAIT → Rdy never asserts.
  - Later read of 0x20 returns the old contents.
- Handshake hold and turnaround:
  - Hold Enable 5 cycles after Rdy → Rdy stays 1 and DataOut stable for all 5.
  - Drop Enable → Rdy=0 next edge.
  - Back-to-back request accepted on the following edge.
- Reset mid-access and zero wait:
  - Assert Reset during WAIT of a write → Rdy=0 and DataOut=0 immediately; storage unchanged.
  - With WAIT_CYCLES=0, Rdy high 2 edges after capture.
- Error reporting (MEM_RESP_ERR_EN defined):
  - Word write Length=1 at Addr=0x000002 → Err=1 with Rdy; memory unchanged.
  - Rd&Wr together → Err=1, DataOut=0xDEADBEEF.
